// File: rtl/contador_sincrono_param.sv
// Parametrised up/down modulo counter with parallel load, terminal count and sticky overflow.
// Define CONTADOR_SATURA_EN to make the counter saturate at its end points instead of wrapping.
module contador_sincrono_param #(
    parameter int     WIDTH = 4,
    parameter longint MOD   = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Top of the count range; all-ones when MOD == 2^WIDTH, so the load clamp never fires then.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (load) begin
            cnt_d = (d > MAX) ? MAX : d;
            ovf_d = 1'b0;
        end else if (en) begin
            if (up) begin
                if (cnt_q == MAX) begin
`ifdef CONTADOR_SATURA_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = '0;
`endif
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
`ifdef CONTADOR_SATURA_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = MAX;
`endif
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign ovf = ovf_q;
    assign tc  = up ? (cnt_q == MAX) : (cnt_q == '0);

endmodule
